// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types for the data-memory arbiter.
//   arb_state_e : who owned the RAM on the last cycle
//   owner_e     : which port a pending read return belongs to
//   UBHW_*      : funct3 size/sign codes understood by the byte-lane RAM
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CPU_OWN    = 2'd1,
    ST_EXT_OWN    = 2'd2,
    ST_EXT_LOCKED = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  localparam logic [2:0] UBHW_B  = 3'b000;
  localparam logic [2:0] UBHW_H  = 3'b001;
  localparam logic [2:0] UBHW_W  = 3'b010;
  localparam logic [2:0] UBHW_BU = 3'b100;
  localparam logic [2:0] UBHW_HU = 3'b101;

  // Width of the starvation counter; STARVE_MAX must fit in it (1..15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_rr_counter.sv
// -----------------------------------------------------------------------------
// dmem_rr_counter
// Saturating count of consecutive CPU grants taken while EXT is waiting.
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset
//   i_clr    : clear (EXT granted, or EXT not waiting); wins over i_inc
//   i_inc    : CPU granted while EXT waits
//   o_at_max : count has reached STARVE_MAX, EXT must win the next tie
// -----------------------------------------------------------------------------
module dmem_rr_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == LP_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported data RAM between the MEM stage (CPU) and an
// external debug/DMA port (EXT). One access per cycle, CPU has priority,
// a starvation counter bounds EXT lockout, ext_lock lets EXT hold a burst.
//   clk, rst          : clock, synchronous active-low reset
//   cpu_* (in)        : MEM-stage request, write flag, address, data, size
//   cpu_stall         : CPU request not granted this cycle (to hazard unit)
//   cpu_rdata/rvalid  : load return, one cycle after the grant
//   ext_valid/ready   : EXT handshake; ext_we/addr/wdata/ubhw/lock request
//   ext_rdata/rvalid  : EXT read return, one cycle after the grant
//   ram_*             : RAM access port; ram_dout is valid one cycle after
//                       the address is presented
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_ubhw,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic [2:0]        ext_ubhw,
  input  logic              ext_lock,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  output logic [2:0]        ram_ubhw,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_e        r_state, w_state_nxt;
  owner_e            r_tag, w_tag_nxt;
  logic              w_gnt_cpu, w_gnt_ext;
  logic              w_starve_hit;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [2:0]        r_ubhw;

  dmem_rr_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_clr    (~ext_valid | w_gnt_ext),
    .i_inc    (w_gnt_cpu & ext_valid),
    .o_at_max (w_starve_hit)
  );

  // EXT only beats a competing CPU request when it has been starved long
  // enough or is in the middle of a locked burst.
  always_comb begin
    w_gnt_ext = ext_valid & (~cpu_req | w_starve_hit | (r_state == ST_EXT_LOCKED));
    w_gnt_cpu = cpu_req & ~w_gnt_ext;
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_tag_nxt   = OWN_NONE;
    if (w_gnt_ext) begin
      w_state_nxt = ext_lock ? ST_EXT_LOCKED : ST_EXT_OWN;
      if (!ext_we) w_tag_nxt = OWN_EXT;
    end else if (w_gnt_cpu) begin
      w_state_nxt = ST_CPU_OWN;
      if (!cpu_we) w_tag_nxt = OWN_CPU;
    end
  end

  // Address/data/size are driven straight through in the grant cycle so the
  // read returns one cycle later; without a grant they hold the last value.
  always_comb begin
    ram_addr = r_addr;
    ram_din  = r_din;
    ram_ubhw = r_ubhw;
    ram_we   = 1'b0;
    if (w_gnt_ext) begin
      ram_addr = ext_addr;
      ram_din  = ext_wdata;
      ram_ubhw = ext_ubhw;
      ram_we   = ext_we;
    end else if (w_gnt_cpu) begin
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
      ram_ubhw = cpu_ubhw;
      ram_we   = cpu_we;
    end
    if (!rst) ram_we = 1'b0;
  end

  assign cpu_stall = cpu_req & ~w_gnt_cpu;
  assign ext_ready = ext_valid & w_gnt_ext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_tag   <= OWN_NONE;
      r_addr  <= '0;
      r_din   <= '0;
      r_ubhw  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= w_tag_nxt;
      if (w_gnt_ext || w_gnt_cpu) begin
        r_addr <= ram_addr;
        r_din  <= ram_din;
        r_ubhw <= ram_ubhw;
      end
    end
  end

  // Return path: the registered tag steers ram_dout to its owner; the
  // non-owner sees zero so reset leaves both data outputs at 0.
  assign cpu_rvalid = (r_tag == OWN_CPU);
  assign ext_rvalid = (r_tag == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? ram_dout : '0;
  assign ext_rdata  = ext_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, ext_valid, ext_we, ext_lock;
  logic [AW-1:0] cpu_addr, ext_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata;
  logic [2:0]    cpu_ubhw, ext_ubhw;
  logic          cpu_stall, cpu_rvalid, ext_ready, ext_rvalid, ram_we;
  logic [DW-1:0] cpu_rdata, ext_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  logic [2:0]    ram_ubhw;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ubhw(cpu_ubhw), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ubhw(ext_ubhw), .ext_lock(ext_lock), .ext_rdata(ext_rdata),
    .ext_rvalid(ext_rvalid), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_ubhw(ram_ubhw), .ram_dout(ram_dout)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA500_0000 + 32'(i) * 32'h0101_0101);
  endfunction

  // Behavioural RAM: 16 words, one-cycle read latency, read-before-write.
  logic [31:0] ram_mem [16];
  bit          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else begin
      ram_dout <= ram_mem[ram_addr[5:2]];
      if (ram_we) ram_mem[ram_addr[5:2]] <= ram_din;
    end
  end

  typedef struct {
    bit rst, creq, cwe, ev, ewe, elock;
    logic [31:0] caddr, cwd, eaddr, ewd;
    logic [2:0]  cub, eub;
  } stim_t;

  typedef struct {
    bit stall, ready, we, crv, erv;
    logic [31:0] addr, din;
    logic [2:0]  ubhw;
  } exp_t;

  exp_t        cyc_q[$];
  logic [31:0] cpu_q[$];
  logic [31:0] ext_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, pending returns, starvation count,
  // whether EXT is inside a locked burst, and the held RAM fields.
  logic [31:0] ref_mem [16];
  int          m_starve = 0;
  bit          m_locked = 0, m_pend_cpu = 0, m_pend_ext = 0;
  logic [31:0] m_addr = 0, m_din = 0;
  logic [2:0]  m_ub = 0;

  task automatic drive(input stim_t s);
    exp_t e;
    bit g_ext, g_cpu;
    @(posedge clk);
    #1;
    rst = s.rst; cpu_req = s.creq; cpu_we = s.cwe; cpu_addr = s.caddr;
    cpu_wdata = s.cwd; cpu_ubhw = s.cub; ext_valid = s.ev; ext_we = s.ewe;
    ext_addr = s.eaddr; ext_wdata = s.ewd; ext_ubhw = s.eub; ext_lock = s.elock;

    g_ext = s.ev && (!s.creq || m_starve == SMAX || m_locked);
    g_cpu = s.creq && !g_ext;
    e.stall = s.creq && !g_cpu;
    e.ready = s.ev && g_ext;
    e.we    = s.rst && (g_ext ? s.ewe : (g_cpu ? s.cwe : 1'b0));
    e.addr  = g_ext ? s.eaddr : (g_cpu ? s.caddr : m_addr);
    e.din   = g_ext ? s.ewd   : (g_cpu ? s.cwd   : m_din);
    e.ubhw  = g_ext ? s.eub   : (g_cpu ? s.cub   : m_ub);
    e.crv   = m_pend_cpu;
    e.erv   = m_pend_ext;
    cyc_q.push_back(e);

    if (!s.rst) begin
      m_starve = 0; m_locked = 0; m_pend_cpu = 0; m_pend_ext = 0;
      m_addr = 0; m_din = 0; m_ub = 0;
    end else begin
      m_pend_cpu = g_cpu && !s.cwe;
      m_pend_ext = g_ext && !s.ewe;
      if (m_pend_cpu) cpu_q.push_back(ref_mem[s.caddr[5:2]]);
      if (m_pend_ext) ext_q.push_back(ref_mem[s.eaddr[5:2]]);
      if (g_cpu && s.cwe) ref_mem[s.caddr[5:2]] = s.cwd;
      if (g_ext && s.ewe) ref_mem[s.eaddr[5:2]] = s.ewd;
      if (g_cpu || g_ext) begin m_addr = e.addr; m_din = e.din; m_ub = e.ubhw; end
      if (!s.ev || g_ext) m_starve = 0;
      else if (g_cpu && m_starve < SMAX) m_starve++;
      m_locked = g_ext && s.elock;
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      chk("cpu_stall",  32'(cpu_stall),  32'(mon_e.stall));
      chk("ext_ready",  32'(ext_ready),  32'(mon_e.ready));
      chk("ram_we",     32'(ram_we),     32'(mon_e.we));
      chk("ram_addr",   ram_addr,        mon_e.addr);
      chk("ram_din",    ram_din,         mon_e.din);
      chk("ram_ubhw",   32'(ram_ubhw),   32'(mon_e.ubhw));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(mon_e.crv));
      chk("ext_rvalid", 32'(ext_rvalid), 32'(mon_e.erv));
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) chk("cpu_rdata_unexpected", 32'd1, 32'd0);
        else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (ext_rvalid) begin
        if (ext_q.size() == 0) chk("ext_rdata_unexpected", 32'd1, 32'd0);
        else chk("ext_rdata", ext_rdata, ext_q.pop_front());
      end
    end
  end

  function automatic stim_t idle_s();
    stim_t s;
    s.rst = 1; s.creq = 0; s.cwe = 0; s.ev = 0; s.ewe = 0; s.elock = 0;
    s.caddr = 0; s.cwd = 0; s.eaddr = 0; s.ewd = 0; s.cub = 3'b010; s.eub = 3'b010;
    return s;
  endfunction

  function automatic stim_t rand_s();
    stim_t s;
    s.rst   = ($urandom_range(0, 63) != 0);
    s.creq  = ($urandom_range(0, 3) != 0);
    s.cwe   = ($urandom_range(0, 2) == 0);
    s.caddr = 32'($urandom_range(0, 15)) << 2;
    s.cwd   = $urandom;
    s.cub   = 3'($urandom_range(0, 7));
    s.ev    = 1'($urandom_range(0, 1));
    s.ewe   = 1'($urandom_range(0, 1));
    s.elock = ($urandom_range(0, 3) == 0);
    s.eaddr = 32'($urandom_range(0, 15)) << 2;
    s.ewd   = $urandom;
    s.eub   = 3'($urandom_range(0, 7));
    return s;
  endfunction

  initial begin
    stim_t s;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    rst = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_ubhw = 0;
    ext_valid = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_ubhw = 0; ext_lock = 0;
    @(posedge clk);

    // Reset, then confirm the internal state came up clean.
    s = idle_s(); s.rst = 0;
    drive(s); drive(s);
    s = idle_s();
    drive(s);
    chk("state_after_reset",  32'(dut.r_state),       32'd0);
    chk("starve_after_reset", 32'(dut.u_starve.r_cnt), 32'd0);

    // CPU alone reads 0x10.
    s = idle_s(); s.creq = 1; s.caddr = 32'h10;
    drive(s);
    s = idle_s(); drive(s); drive(s);

    // Sustained contention: four CPU grants then one EXT grant, repeating.
    s = idle_s(); s.creq = 1; s.caddr = 32'h04; s.ev = 1; s.eaddr = 32'h08;
    for (int i = 0; i < 11; i++) drive(s);
    s = idle_s(); drive(s);

    // Locked burst under CPU pressure, then lock released.
    s = idle_s(); s.creq = 1; s.caddr = 32'h0C; s.ev = 1; s.elock = 1; s.eaddr = 32'h14;
    for (int i = 0; i < 8; i++) drive(s);
    s.elock = 0;
    drive(s);
    s.ev = 0;
    drive(s); drive(s);

    // EXT word write, CPU readback; then CPU read followed by EXT write.
    s = idle_s(); s.ev = 1; s.ewe = 1; s.eaddr = 32'h20; s.ewd = 32'h12345678; s.eub = 3'b010;
    drive(s);
    s = idle_s(); s.creq = 1; s.caddr = 32'h20;
    drive(s);
    s = idle_s(); s.ev = 1; s.ewe = 1; s.eaddr = 32'h24; s.ewd = 32'hCAFEF00D;
    drive(s);
    s = idle_s(); s.ev = 1; s.eaddr = 32'h24;
    drive(s);

    // Reset with a CPU read in the grant cycle: its return is dropped.
    s = idle_s(); s.rst = 0; s.creq = 1; s.caddr = 32'h10;
    drive(s);
    s = idle_s();
    drive(s);
    chk("state_after_midreset",  32'(dut.r_state),        32'd0);
    chk("starve_after_midreset", 32'(dut.u_starve.r_cnt), 32'd0);
    drive(s); drive(s);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) drive(rand_s());
    s = idle_s();
    drive(s); drive(s); drive(s);

    @(negedge clk);
    #1;
    chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("ext_q_drained", 32'(ext_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
